// File: rtl/branch_resolve.sv
// Branch resolution at the M stage: carries D-stage predictions through E and M,
// flags mispredictions with a redirect PC, and keeps saturating performance counters.
module branch_resolve #(
  parameter int unsigned FALLTHRU_OFF = 32'd8,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallE,
  input  logic             stallM,
  input  logic             flushE,
  input  logic             flushM,
  input  logic             branchD,
  input  logic             pred_takeD,
  input  logic [31:0]      pcD,
  input  logic [31:0]      targetD,
  input  logic             actual_takeM,
  output logic             mispredM,
  output logic             flush_reqM,
  output logic [31:0]      redirect_pcM,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [31:0] FALLTHRU_C = 32'(FALLTHRU_OFF);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic        valid_e_q, pred_e_q;
  logic [31:0] pc_e_q, target_e_q;
  logic        valid_m_q, pred_m_q;
  logic [31:0] pc_m_q, target_m_q;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic        retire_s;
  logic        mispred_s;
  logic [31:0] redirect_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mispred_s) state_d = RECOVER; else state_d = IDLE;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The slot after a mispredict is wrong-path, so RECOVER (and reset) suppresses retirement.
  always_comb begin
    retire_s   = 1'b0;
    mispred_s  = 1'b0;
    redirect_s = 32'd0;
    case (state_q)
      IDLE:    retire_s = valid_m_q & ~stallM & ~rst;
      RECOVER: retire_s = 1'b0;
      default: retire_s = 1'b0;
    endcase
    mispred_s = retire_s & (pred_m_q != actual_takeM);
    if (mispred_s) begin
      if (actual_takeM) begin
        redirect_s = target_m_q;
      end else begin
        redirect_s = pc_m_q + FALLTHRU_C;
      end
    end else begin
      redirect_s = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e_q <= 1'b0;
    end else if (flushE || mispred_s) begin
      valid_e_q <= 1'b0;
    end else if (!stallE) begin
      valid_e_q <= branchD;
    end else begin
      valid_e_q <= valid_e_q;
    end
    if (!stallE) begin
      pred_e_q   <= pred_takeD;
      pc_e_q     <= pcD;
      target_e_q <= targetD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m_q <= 1'b0;
    end else if (flushM) begin
      valid_m_q <= 1'b0;
    end else if (!stallM) begin
      valid_m_q <= valid_e_q;
    end else begin
      valid_m_q <= valid_m_q;
    end
    if (!stallM) begin
      pred_m_q   <= pred_e_q;
      pc_m_q     <= pc_e_q;
      target_m_q <= target_e_q;
    end
  end

  always_comb begin
    branch_cnt_d  = sat_inc(branch_cnt_q, retire_s);
    mispred_cnt_d = sat_inc(mispred_cnt_q, mispred_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= {CNT_W{1'b0}};
      mispred_cnt_q <= {CNT_W{1'b0}};
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispredM     = mispred_s;
  assign flush_reqM   = mispred_s;
  assign redirect_pcM = redirect_s;
  assign branch_cnt   = branch_cnt_q;
  assign mispred_cnt  = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve, built with 4-bit counters so saturation is reachable.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst, stallE, stallM, flushE, flushM;
  logic        branchD, pred_takeD, actual_takeM;
  logic [31:0] pcD, targetD;
  logic        mispredM, flush_reqM;
  logic [31:0] redirect_pcM;
  logic [3:0]  branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mp = 0;

  branch_resolve #(.FALLTHRU_OFF(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushM(flushM), .branchD(branchD), .pred_takeD(pred_takeD),
    .pcD(pcD), .targetD(targetD), .actual_takeM(actual_takeM),
    .mispredM(mispredM), .flush_reqM(flush_reqM), .redirect_pcM(redirect_pcM),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulse(input string tag, input logic exp_mis, input logic [31:0] exp_pc);
    chk({tag, "_mispred"}, {31'd0, mispredM}, {31'd0, exp_mis});
    chk({tag, "_flushreq"}, {31'd0, flush_reqM}, {31'd0, exp_mis});
    chk({tag, "_redirect"}, redirect_pcM, exp_pc);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_branch_cnt"}, {28'd0, branch_cnt}, exp_br);
    chk({tag, "_mispred_cnt"}, {28'd0, mispred_cnt}, exp_mp);
  endtask

  task automatic issue(input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
    branchD = 1'b1; pred_takeD = pred; pcD = pc; targetD = tgt;
  endtask

  function automatic int sat15(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  initial begin
    rst = 1'b1; stallE = 1'b0; stallM = 1'b0; flushE = 1'b0; flushM = 1'b0;
    branchD = 1'b0; pred_takeD = 1'b0; actual_takeM = 1'b0; pcD = 32'd0; targetD = 32'd0;
    cyc(); cyc();
    #4;
    chk_pulse("reset", 1'b0, 32'd0);
    chk_cnt("reset");
    rst = 1'b0;
    cyc();

    // Test 1: correctly predicted taken branch
    issue(1'b1, 32'h100, 32'h200);
    #4 chk_pulse("t1_d", 1'b0, 32'd0);
    cyc();
    branchD = 1'b0;
    #4 chk_pulse("t1_e", 1'b0, 32'd0);
    cyc();
    actual_takeM = 1'b1;
    #4 chk_pulse("t1_m", 1'b0, 32'd0);
    cyc();
    exp_br = 1;
    actual_takeM = 1'b0;
    #4 chk_cnt("t1_after");
    cyc();

    // Test 2: predicted not-taken, resolves taken
    issue(1'b0, 32'h100, 32'h200);
    cyc();
    branchD = 1'b0;
    cyc();
    actual_takeM = 1'b1;
    #4 chk_pulse("t2_m", 1'b1, 32'h200);
    cyc();
    exp_br = 2; exp_mp = 1;
    actual_takeM = 1'b0;
    #4 chk_pulse("t2_after", 1'b0, 32'd0);
    chk_cnt("t2_after");
    cyc();

    // Test 3: fall-through wraps; younger branch in E is squashed
    issue(1'b1, 32'hFFFF_FFFC, 32'h40);
    cyc();
    issue(1'b0, 32'h300, 32'h400);
    cyc();
    branchD = 1'b0; actual_takeM = 1'b0;
    #4 chk_pulse("t3_m", 1'b1, 32'h4);
    cyc();
    exp_br = 3; exp_mp = 2;
    actual_takeM = 1'b1;
    #4 chk_pulse("t3_recover", 1'b0, 32'd0);
    cyc();
    #4 chk_pulse("t3_squashed", 1'b0, 32'd0);
    chk_cnt("t3_after");
    cyc();

    // Test 4: mispredicted branch held in M by stallM for 3 cycles
    actual_takeM = 1'b0;
    issue(1'b1, 32'h500, 32'h600);
    cyc();
    branchD = 1'b0;
    cyc();
    stallM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4 chk_pulse($sformatf("t4_stall%0d", i), 1'b0, 32'd0);
      chk_cnt($sformatf("t4_stall%0d", i));
      cyc();
    end
    stallM = 1'b0;
    #4 chk_pulse("t4_release", 1'b1, 32'h508);
    cyc();
    exp_br = 4; exp_mp = 3;
    #4 chk_pulse("t4_after", 1'b0, 32'd0);
    chk_cnt("t4_after");
    cyc();

    // Test 5: 20 mispredictions drive both 4-bit counters into saturation
    for (int i = 0; i < 20; i++) begin
      issue(1'b1, 32'h1000 + 32'(i * 16), 32'h2000);
      cyc();
      branchD = 1'b0;
      cyc();
      actual_takeM = 1'b0;
      #4 chk_pulse($sformatf("t5_br%0d", i), 1'b1, 32'h1008 + 32'(i * 16));
      cyc();
      exp_br = sat15(exp_br); exp_mp = sat15(exp_mp);
      #4 chk_cnt($sformatf("t5_br%0d", i));
      cyc();
    end
    chk("t5_branch_sat", {28'd0, branch_cnt}, 32'hF);
    chk("t5_mispred_sat", {28'd0, mispred_cnt}, 32'hF);

    // Test 6: reset with branches in E and M discards both without a pulse
    issue(1'b0, 32'h700, 32'h800);
    cyc();
    issue(1'b0, 32'h900, 32'hA00);
    cyc();
    branchD = 1'b0; actual_takeM = 1'b1; rst = 1'b1;
    #4 chk_pulse("t6_in_reset", 1'b0, 32'd0);
    cyc();
    rst = 1'b0;
    exp_br = 0; exp_mp = 0;
    #4 chk_pulse("t6_post_reset", 1'b0, 32'd0);
    chk_cnt("t6_post_reset");
    cyc();
    #4 chk_pulse("t6_drain", 1'b0, 32'd0);
    cyc();
    chk_cnt("t6_final");

    // flushM alongside a valid M: still evaluated this cycle, then cleared
    issue(1'b0, 32'hB00, 32'hC00);
    cyc();
    branchD = 1'b0;
    cyc();
    flushM = 1'b1; actual_takeM = 1'b1;
    #4 chk_pulse("flm_m", 1'b1, 32'hC00);
    cyc();
    flushM = 1'b0;
    exp_br = 1; exp_mp = 1;
    #4 chk_cnt("flm_after");
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
